// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Owner encoding, tag layout and read-latency bounds.
package mem_port_arbiter_pkg;

  localparam int MEMARB_RD_LAT_MIN = 1;
  localparam int MEMARB_RD_LAT_MAX = 4;
  localparam int MEMARB_STARVE_W   = 4;
  localparam int MEMARB_TAG_W      = 3;

  localparam logic MEMARB_OWNER_INST = 1'b0;
  localparam logic MEMARB_OWNER_DATA = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_store;
  } memarb_tag_t;

endpackage

// File: rtl/memarb_tag_pipe.sv
// Fixed-latency tag shift register tracking in-flight SRAM accesses.
// Async clear drops every outstanding tag at once.
module memarb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  memarb_tag_t tag_in,
  output memarb_tag_t tag_out
);

  logic [MEMARB_TAG_W-1:0] stage [RD_LAT];

  // Shift one slot per cycle; stage 0 captures this cycle's grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = memarb_tag_t'(stage[RD_LAT-1]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter in front of the single-port SRAM.
// Data wins by default; a starved fetch is forced through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam int LAT =
    (RD_LAT < MEMARB_RD_LAT_MIN) ? MEMARB_RD_LAT_MIN :
    (RD_LAT > MEMARB_RD_LAT_MAX) ? MEMARB_RD_LAT_MAX :
    RD_LAT;

  localparam logic [MEMARB_STARVE_W-1:0] STARVE_LIM =
    MEMARB_STARVE_W'(STARVE_MAX);

  logic [MEMARB_STARVE_W-1:0] starve_cnt;
  logic        inst_force;
  logic        gnt_inst;
  logic        gnt_data;
  memarb_tag_t tag_in;
  memarb_tag_t tag_out;

  // Pick at most one winner; nothing is granted while in reset
  always_comb begin
    inst_force = inst_req && (starve_cnt == STARVE_LIM);
    gnt_data   = !reset && data_req && !inst_force;
    gnt_inst   = !reset && inst_req && !gnt_data;
  end

  // Count data wins that bypass a waiting fetch, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt_inst || !inst_req) begin
      starve_cnt <= '0;
    end else if (gnt_data && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Steer the winner onto the SRAM command port
  always_comb begin
    sram_en      = 1'b0;
    sram_wen     = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    tag_in       = '0;
    unique case (1'b1)
      gnt_data: begin
        sram_en         = 1'b1;
        sram_wen        = data_wr ? data_wstrb : 4'b0000;
        sram_addr       = data_addr;
        sram_wdata      = data_wdata;
        data_addr_ok    = 1'b1;
        tag_in.valid    = 1'b1;
        tag_in.owner    = MEMARB_OWNER_DATA;
        tag_in.is_store = data_wr;
      end
      gnt_inst: begin
        sram_en         = 1'b1;
        sram_addr       = inst_addr;
        inst_addr_ok    = 1'b1;
        tag_in.valid    = 1'b1;
        tag_in.owner    = MEMARB_OWNER_INST;
      end
      default: begin
      end
    endcase
  end

  memarb_tag_pipe #(
    .RD_LAT (LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Route the returning SRAM word to whoever issued it
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (tag_out.valid) begin
      if (tag_out.owner == MEMARB_OWNER_INST) begin
        inst_data_ok = 1'b1;
        inst_rdata   = sram_rdata;
      end else begin
        data_data_ok = 1'b1;
        data_rdata   = tag_out.is_store ? 32'h0 : sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT 2, 1 and 4 instances share stimulus.
// Reference model tracks grants, memory contents and response schedule.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N = 3;

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  logic [N-1:0] inst_addr_ok;
  logic [N-1:0] inst_data_ok;
  logic [N-1:0] data_addr_ok;
  logic [N-1:0] data_data_ok;
  logic [N-1:0] sram_en;
  logic [31:0]  inst_rdata [N];
  logic [31:0]  data_rdata [N];
  logic [31:0]  sram_addr  [N];
  logic [31:0]  sram_wdata [N];
  logic [31:0]  sram_rdata [N];
  logic [3:0]   sram_wen   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(
      .RD_LAT     (lat_of(g)),
      .STARVE_MAX (3)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .sram_en      (sram_en[g]),
      .sram_wen     (sram_wen[g]),
      .sram_addr    (sram_addr[g]),
      .sram_wdata   (sram_wdata[g]),
      .sram_rdata   (sram_rdata[g])
    );
  end

  function automatic logic [5:0] widx(logic [31:0] a);
    return {a[28], a[12], a[5:2]};
  endfunction

  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(i);
    case (i)
      0:       return 32'h0000_0011;
      1:       return 32'h0000_0022;
      2:       return 32'h0000_0033;
      32:      return 32'h02C0_0000;
      default: return {b, 8'h5A, ~b, 8'hC3};
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w,
                                        logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
    end
    return r;
  endfunction

  // SRAM behavioural model, one read pipe per latency variant
  logic [31:0] mem [64];
  logic        mem_init = 1'b0;
  logic [31:0] rp [N][4];
  logic [3:0]  rv [N];
  logic [31:0] noise = 32'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (sram_en[0] && sram_wen[0] != 4'b0) begin
      mem[widx(sram_addr[0])] <=
        merge(mem[widx(sram_addr[0])], sram_wdata[0], sram_wen[0]);
    end
    for (int g = 0; g < N; g++) begin
      for (int k = 3; k > 0; k--) begin
        rp[g][k] <= rp[g][k-1];
        rv[g][k] <= rv[g][k-1];
      end
      rp[g][0] <= mem[widx(sram_addr[g])];
      rv[g][0] <= sram_en[g] && (sram_wen[g] == 4'b0);
    end
    noise <= $urandom;
  end

  always_comb begin
    for (int g = 0; g < N; g++) begin
      sram_rdata[g] = rv[g][lat_of(g)-1] ? rp[g][lat_of(g)-1] : noise;
    end
  end

  // Reference model state
  typedef struct {
    bit          v;
    bit          owner;
    bit          st;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] rmem [64];
  rsp_t        ep [N][5];
  int          starve;
  int          errors = 0;
  int          checks = 0;
  bit          last_mi;
  bit          last_md;
  logic        obs_i;

  task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lat%0d got=%h exp=%h t=%0t",
             tag, lat_of(g), obs, exp, $time);
    end
  endtask

  task automatic clr(output rsp_t r);
    r.v = 1'b0; r.owner = 1'b0; r.st = 1'b0; r.d = 32'h0;
  endtask

  task automatic step();
    bit          md;
    bit          mi;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  ewen;
    rsp_t        e;
    rsp_t        nr;
    @(negedge clk);
    md   = !reset && data_req && !(inst_req && starve == 3);
    mi   = !reset && inst_req && !md;
    ea   = md ? data_addr : (mi ? inst_addr : 32'h0);
    ew   = md ? data_wdata : 32'h0;
    ewen = (md && data_wr) ? data_wstrb : 4'h0;
    obs_i = inst_addr_ok[0];
    for (int g = 0; g < N; g++) begin
      chk("inst_addr_ok", g, 32'(inst_addr_ok[g]), 32'(mi));
      chk("data_addr_ok", g, 32'(data_addr_ok[g]), 32'(md));
      chk("sram_en", g, 32'(sram_en[g]), 32'(mi | md));
      chk("sram_wen", g, 32'(sram_wen[g]), 32'(ewen));
      chk("sram_addr", g, sram_addr[g], ea);
      chk("sram_wdata", g, sram_wdata[g], ew);
      if (reset) clr(e);
      else e = ep[g][0];
      chk("inst_data_ok", g, 32'(inst_data_ok[g]), 32'(e.v && !e.owner));
      chk("inst_rdata", g, inst_rdata[g],
          (e.v && !e.owner) ? e.d : 32'h0);
      chk("data_data_ok", g, 32'(data_data_ok[g]), 32'(e.v && e.owner));
      chk("data_rdata", g, data_rdata[g],
          (e.v && e.owner && !e.st) ? e.d : 32'h0);
    end
    clr(nr);
    if (md) begin
      nr.v = 1'b1;
      nr.owner = 1'b1;
      nr.st = data_wr;
      if (data_wr) begin
        rmem[widx(data_addr)] =
          merge(rmem[widx(data_addr)], data_wdata, data_wstrb);
      end else begin
        nr.d = rmem[widx(data_addr)];
      end
    end else if (mi) begin
      nr.v = 1'b1;
      nr.d = rmem[widx(inst_addr)];
    end
    if (reset || mi || !inst_req) starve = 0;
    else if (md && starve < 3) starve++;
    for (int g = 0; g < N; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (reset) clr(ep[g][k]);
        else ep[g][k] = ep[g][k+1];
      end
      clr(ep[g][4]);
      if (nr.v) ep[g][lat_of(g)-1] = nr;
    end
    last_mi = mi;
    last_md = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    repeat (n) step();
  endtask

  task automatic both_held(int n, output logic [7:0] seq);
    seq = '0;
    inst_req  = 1'b1;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seq[i] = obs_i;
      if (last_mi) inst_addr = inst_addr + 32'h4;
      if (last_md) data_addr = data_addr ^ 32'hC;
    end
  endtask

  initial begin
    logic [7:0] seq;
    for (int i = 0; i < 64; i++) rmem[i] = init_word(i);
    for (int g = 0; g < N; g++) begin
      for (int k = 0; k < 5; k++) clr(ep[g][k]);
    end
    starve     = 0;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    inst_req  = 1'b1;
    data_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    step();
    step();
    reset = 1'b0;
    idle(2);

    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    step();
    idle(5);

    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'b0100;
    data_addr  = 32'h0000_1002;
    data_wdata = 32'hABAB_ABAB;
    step();
    idle(5);
    data_req  = 1'b1;
    data_addr = 32'h0000_1000;
    step();
    idle(5);

    inst_addr = 32'h1C00_0000;
    data_addr = 32'h0000_0004;
    both_held(8, seq);
    checks++;
    assert (seq === 8'b1000_1000) else begin
      errors++;
      $error("FAIL grant_seq got=%b exp=%b", seq, 8'b1000_1000);
    end
    idle(6);

    data_req  = 1'b1;
    data_addr = 32'h0;
    step();
    data_addr = 32'h4;
    step();
    data_addr = 32'h8;
    step();
    idle(6);

    inst_addr = 32'h1C00_0000;
    data_addr = 32'h0000_0004;
    both_held(2, seq);
    data_addr = 32'h8;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    inst_addr = 32'h1C00_0000;
    data_addr = 32'h0000_0004;
    both_held(4, seq);
    checks++;
    assert (seq[3:0] === 4'b1000) else begin
      errors++;
      $error("FAIL post_reset_seq got=%b exp=%b", seq[3:0], 4'b1000);
    end
    idle(5);
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    step();
    idle(5);

    repeat (600) begin
      if (!inst_req || last_mi || $urandom_range(0, 15) == 0) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom & 32'h1000_103C;
      end
      if (!data_req || last_md || $urandom_range(0, 15) == 0) begin
        data_req   = $urandom_range(0, 1) != 0;
        data_wr    = $urandom_range(0, 1) != 0;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
        data_addr  = $urandom & 32'h0000_103F;
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
